// File: rtl/axi_selftest_pkg.sv
// rtl/axi_selftest_pkg.sv - shared constants and types for the AXI4-Lite self-test master
package axi_selftest_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int ERR_CNT_W = 8;

    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
    localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_NEXT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/axi_selftest_pattern_gen.sv
// rtl/axi_selftest_pattern_gen.sv - expected-data generator: seed+idx, or Galois LFSR with AXI_SELFTEST_LFSR_EN
module axi_selftest_pattern_gen
    import axi_selftest_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_seed,
    input  logic                  i_step,
    output logic [DATA_WIDTH-1:0] o_value
);

    logic [DATA_WIDTH-1:0] r_value;
    logic [DATA_WIDTH-1:0] w_load_val;
    logic [DATA_WIDTH-1:0] w_step_val;

`ifdef AXI_SELFTEST_LFSR_EN
    localparam logic [DATA_WIDTH-1:0] TAPS = (DATA_WIDTH == 64) ? DATA_WIDTH'(LFSR_TAPS_64)
                                                                : DATA_WIDTH'(LFSR_TAPS_32);

    // An all-zero state would lock the LFSR, so a zero seed becomes 1.
    assign w_load_val = (i_seed == '0) ? DATA_WIDTH'(1) : i_seed;
    assign w_step_val = (r_value >> 1) ^ (r_value[0] ? TAPS : '0);
`else
    assign w_load_val = i_seed;
    assign w_step_val = r_value + DATA_WIDTH'(1);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= w_load_val;
        end else if (i_step) begin
            r_value <= w_step_val;
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/axi_lite_selftest_master.sv
// rtl/axi_lite_selftest_master.sv - AXI4-Lite write/readback/compare sweep master (pattern: AXI_SELFTEST_LFSR_EN)
module axi_lite_selftest_master
    import axi_selftest_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    NUM_REGS       = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    ADDR_STRIDE    = DATA_WIDTH / 8,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    input  logic                    mode,
    input  logic [DATA_WIDTH-1:0]   seed,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [ERR_CNT_W-1:0]    err_count,
    output logic [7:0]              first_err_idx,
    output logic [DATA_WIDTH-1:0]   first_err_data,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES) + 1;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [7:0]             r_idx;
    logic                   r_mode;
    logic                   r_phase_rd;
    logic [DATA_WIDTH-1:0]  r_seed;
    logic                   r_aw_done;
    logic                   r_w_done;
    logic [WDOG_W-1:0]      r_wdog;
    logic [ERR_CNT_W-1:0]   r_err_cnt;
    logic [7:0]             r_first_idx;
    logic [DATA_WIDTH-1:0]  r_first_data;
    logic                   r_pass;
    logic                   r_timeout;

    logic                   w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_any_hs;
    logic                   w_waiting, w_expire, w_last;
    logic                   w_wr_err, w_rd_err, w_err;
    logic                   w_pat_load, w_pat_step;
    logic [DATA_WIDTH-1:0]  w_pat_seed, w_expected;
    logic [ADDR_WIDTH-1:0]  w_addr;

    axi_selftest_pattern_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pattern (
        .i_clk   (ACLK),
        .i_rst   (ARESET),
        .i_load  (w_pat_load),
        .i_seed  (w_pat_seed),
        .i_step  (w_pat_step),
        .o_value (w_expected)
    );

    assign w_aw_hs  = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_w_hs   = M_AXI_WVALID  & M_AXI_WREADY;
    assign w_b_hs   = M_AXI_BREADY  & M_AXI_BVALID;
    assign w_ar_hs  = M_AXI_ARVALID & M_AXI_ARREADY;
    assign w_r_hs   = M_AXI_RREADY  & M_AXI_RVALID;
    assign w_any_hs = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;

    assign w_waiting = (r_state == ST_WR) || (r_state == ST_WR_RESP) ||
                       (r_state == ST_RD_ADDR) || (r_state == ST_RD_DATA);
    // A handshake in the expiring cycle still wins over the watchdog.
    assign w_expire  = w_waiting && !w_any_hs && (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
    assign w_last    = (r_idx == 8'(NUM_REGS - 1));

    assign w_wr_err  = w_b_hs && (M_AXI_BRESP != RESP_OKAY);
    assign w_rd_err  = w_r_hs && ((M_AXI_RRESP != RESP_OKAY) || (M_AXI_RDATA != w_expected));
    assign w_err     = w_wr_err | w_rd_err;

    assign w_pat_seed = (r_state == ST_IDLE) ? seed : r_seed;
    assign w_addr     = BASE_ADDR + ADDR_WIDTH'(r_idx) * ADDR_WIDTH'(ADDR_STRIDE);

    always_comb begin
        w_next_state = r_state;
        w_pat_load   = 1'b0;
        w_pat_step   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_WR;
                    w_pat_load   = 1'b1;
                end
            end
            ST_WR: begin
                if (w_expire) begin
                    w_next_state = ST_DONE;
                end else if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_next_state = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (w_expire) begin
                    w_next_state = ST_DONE;
                end else if (w_b_hs) begin
                    w_next_state = r_mode ? ST_NEXT : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                if (w_expire) begin
                    w_next_state = ST_DONE;
                end else if (w_ar_hs) begin
                    w_next_state = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (w_expire) begin
                    w_next_state = ST_DONE;
                end else if (w_r_hs) begin
                    w_next_state = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (w_last) begin
                    if (r_mode && !r_phase_rd) begin
                        w_next_state = ST_RD_ADDR;
                        w_pat_load   = 1'b1;
                    end else begin
                        w_next_state = ST_DONE;
                    end
                end else begin
                    w_pat_step   = 1'b1;
                    w_next_state = (r_mode && r_phase_rd) ? ST_RD_ADDR : ST_WR;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_mode       <= 1'b0;
            r_phase_rd   <= 1'b0;
            r_seed       <= '0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_wdog       <= '0;
            r_err_cnt    <= '0;
            r_first_idx  <= '0;
            r_first_data <= '0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_aw_done <= (r_state == ST_WR) && (w_next_state == ST_WR) && (r_aw_done || w_aw_hs);
            r_w_done  <= (r_state == ST_WR) && (w_next_state == ST_WR) && (r_w_done || w_w_hs);

            if (!w_waiting || w_any_hs || (w_next_state != r_state)) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + WDOG_W'(1);
            end

            if (r_state == ST_IDLE && start) begin
                r_mode       <= mode;
                r_seed       <= seed;
                r_idx        <= '0;
                r_phase_rd   <= 1'b0;
                r_err_cnt    <= '0;
                r_first_idx  <= '0;
                r_first_data <= '0;
                r_pass       <= 1'b0;
                r_timeout    <= 1'b0;
            end

            if (r_state == ST_NEXT) begin
                if (!w_last) begin
                    r_idx <= r_idx + 8'd1;
                end else if (r_mode && !r_phase_rd) begin
                    r_idx      <= '0;
                    r_phase_rd <= 1'b1;
                end
            end

            if (w_err) begin
                if (r_err_cnt == '0) begin
                    r_first_idx  <= r_idx;
                    r_first_data <= w_wr_err ? '0 : M_AXI_RDATA;
                end
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                end
            end

            if (w_expire) begin
                r_timeout <= 1'b1;
            end

            if (w_next_state == ST_DONE && r_state != ST_DONE) begin
                r_pass <= !w_expire && !r_timeout && (r_err_cnt == '0);
            end
        end
    end

    assign busy           = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done           = (r_state == ST_DONE);
    assign pass           = r_pass;
    assign timeout        = r_timeout;
    assign err_count      = r_err_cnt;
    assign first_err_idx  = r_first_idx;
    assign first_err_data = r_first_data;

    assign M_AXI_AWADDR   = w_addr;
    assign M_AXI_AWPROT   = 3'b000;
    assign M_AXI_AWVALID  = (r_state == ST_WR) && !r_aw_done;
    assign M_AXI_WDATA    = w_expected;
    assign M_AXI_WSTRB    = '1;
    assign M_AXI_WVALID   = (r_state == ST_WR) && !r_w_done;
    assign M_AXI_BREADY   = (r_state == ST_WR_RESP);
    assign M_AXI_ARADDR   = w_addr;
    assign M_AXI_ARPROT   = 3'b000;
    assign M_AXI_ARVALID  = (r_state == ST_RD_ADDR);
    assign M_AXI_RREADY   = (r_state == ST_RD_DATA);

endmodule
